// File: rtl/router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | router_pkg : shared types and constants for fifo_rr_router           |
// | Rev 1.0    : initial release                                         |
// +----------------------------------------------------------------------+
package router_pkg;

    localparam int DATA_W  = 6;
    localparam int N_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        PUSH    = 2'd3
    } state_t;

    function automatic logic [1:0] dest_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1:DATA_W-2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter_4 : combinational round-robin search starting at rr_ptr   |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module rr_arbiter_4
    import router_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [1:0]         rr_ptr,
    output logic [1:0]         grant,
    output logic               valid
);

    logic [1:0] idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = N_PORTS - 1; off >= 0; off--) begin
            idx = rr_ptr + 2'(off);
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rr_router : round-robin pop from 4 source FIFOs, push by dest   |
// | Rev 1.0        : initial release                                     |
// +----------------------------------------------------------------------+
module fifo_rr_router
    import router_pkg::*;
#(
    parameter int STALL_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [N_PORTS-1:0]        fifo_empty_in,
    input  logic [N_PORTS*DATA_W-1:0] data_in,
    output logic [N_PORTS-1:0]        fifo_rd_out,
    input  logic [N_PORTS-1:0]        al_full_in,
    output logic [N_PORTS-1:0]        fifo_wr_out,
    output logic [DATA_W-1:0]         data_out,
    output logic                      idle,
    output logic                      err_stall
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    state_t             state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         dest_q, dest_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               err_stall_q, err_stall_d;

    logic [1:0]         arb_grant;
    logic               arb_valid;
    logic [DATA_W-1:0]  lane_word;

    rr_arbiter_4 u_arb (
        .req    (~fifo_empty_in),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    assign lane_word = data_in[32'(grant_q) * DATA_W +: DATA_W];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        dest_d      = dest_q;
        hold_d      = hold_q;
        stall_cnt_d = stall_cnt_q;
        err_stall_d = 1'b0;
        fifo_rd_out = '0;
        fifo_wr_out = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_grant;
                    state_d = POP;
                end
            end
            POP: begin
                fifo_rd_out = 4'b0001 << grant_q;
                rr_ptr_d    = grant_q + 2'd1;
                state_d     = CAPTURE;
            end
            CAPTURE: begin
                hold_d  = lane_word;
                dest_d  = dest_of(lane_word);
                state_d = PUSH;
            end
            PUSH: begin
                if (!al_full_in[dest_q]) begin
                    fifo_wr_out = 4'b0001 << dest_q;
                    stall_cnt_d = '0;
                    if (arb_valid) begin
                        grant_d = arb_grant;
                        state_d = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    // Counter saturates at the limit, so the error fires only once per stall.
                    if (stall_cnt_q != CNT_W'(STALL_LIMIT)) begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                    err_stall_d = (stall_cnt_q == CNT_W'(STALL_LIMIT - 1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            dest_q      <= '0;
            hold_q      <= '0;
            stall_cnt_q <= '0;
            err_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            dest_q      <= dest_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
            err_stall_q <= err_stall_d;
        end
    end

    assign data_out  = hold_q;
    assign idle      = (state_q == IDLE);
    assign err_stall = err_stall_q;

endmodule
`default_nettype wire
